// File: rtl/md_seq_unit.sv
// md_seq_unit: sequential multiplier (radix-2 Booth) and divider (non-restoring on magnitudes), one bit per clock.
// Define MD_SEQ_REMAINDER_EN to add the data_remainder output and its remainder-correction logic.
module md_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MD_SEQ_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;

    // acc: Booth upper half / signed partial remainder; q: multiplier / dividend-then-quotient
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             bfix_q, bfix_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef MD_SEQ_REMAINDER_EN
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] rmag, rem_val;
`endif

    logic             start, finish, last;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] m_ext, add_in, sum, mul_acc;
    logic             add_sub;
    logic [1:0]       booth;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   mul_hi;
    logic             mul_exc;
    logic [WIDTH-1:0] quo;

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? (ctrl_MULT ? MUL : DIV) : IDLE;
            MUL, DIV:   if (finish) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE, DONE: start = ctrl_MULT | ctrl_DIV;
            MUL: begin
                busy   = 1'b1;
                finish = last;
            end
            DIV: begin
                busy   = 1'b1;
                finish = last | dz_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_neg = ctrl_signed & data_operandA[WIDTH-1];
        b_neg = ctrl_signed & data_operandB[WIDTH-1];
        a_mag = a_neg ? (~data_operandA + 1'b1) : data_operandA;
        b_mag = b_neg ? (~data_operandB + 1'b1) : data_operandB;

        m_ext = {m_q[WIDTH], m_q};
        booth = {q_q[0], q1_q};
        if (state_q == DIV) begin
            add_in  = {acc_q[WIDTH:0], q_q[WIDTH-1]};
            add_sub = ~acc_q[WIDTH+1];
        end else begin
            add_in  = acc_q;
            add_sub = (booth == 2'b10);
        end
        sum     = add_sub ? (add_in - m_ext) : (add_in + m_ext);
        mul_acc = (booth[1] ^ booth[0]) ? sum : acc_q;

        // Booth treats the multiplier as signed; an unsigned multiplier with MSB set needs M<<WIDTH added back
        prod    = {acc_q[WIDTH-1:0], q_q} + (bfix_q ? {m_q[WIDTH-1:0], {WIDTH{1'b0}}} : {2*WIDTH{1'b0}});
        mul_hi  = prod[2*WIDTH-1:WIDTH-1];
        mul_exc = sgn_q ? ~((&mul_hi) | ~(|mul_hi)) : (|prod[2*WIDTH-1:WIDTH]);
        quo     = qneg_q ? (~q_q + 1'b1) : q_q;
`ifdef MD_SEQ_REMAINDER_EN
        rmag    = acc_q[WIDTH+1] ? (acc_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_val = rneg_q ? (~rmag + 1'b1) : rmag;
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        q_d    = q_q;
        m_d    = m_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        sgn_d  = sgn_q;
        qneg_d = qneg_q;
        bfix_d = bfix_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        res_d  = res_q;
        exc_d  = exc_q;
        rdy_d  = finish;
`ifdef MD_SEQ_REMAINDER_EN
        rneg_d = rneg_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
`endif
        if (start) begin
            acc_d  = '0;
            q1_d   = 1'b0;
            cnt_d  = '0;
            sgn_d  = ctrl_signed;
            qneg_d = a_neg ^ b_neg;
            bfix_d = ~ctrl_signed & data_operandB[WIDTH-1];
            dz_d   = (data_operandB == '0);
            ovf_d  = ctrl_signed && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                     && (data_operandB == {WIDTH{1'b1}});
`ifdef MD_SEQ_REMAINDER_EN
            rneg_d = a_neg;
            dvd_d  = data_operandA;
`endif
            if (ctrl_MULT) begin
                q_d = data_operandB;
                m_d = {a_neg, data_operandA};
            end else begin
                q_d = a_mag;
                m_d = {1'b0, b_mag};
            end
        end else if (finish) begin
            if (state_q == MUL) begin
                res_d = prod[WIDTH-1:0];
                exc_d = mul_exc;
`ifdef MD_SEQ_REMAINDER_EN
                rem_d = '0;
`endif
            end else if (dz_q) begin
                res_d = '0;
                exc_d = 1'b1;
`ifdef MD_SEQ_REMAINDER_EN
                rem_d = dvd_q;
`endif
            end else begin
                // MIN / -1 already yields MIN from the magnitude path; only the flag is special
                res_d = quo;
                exc_d = ovf_q;
`ifdef MD_SEQ_REMAINDER_EN
                rem_d = rem_val;
`endif
            end
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == MUL) begin
                acc_d = {mul_acc[WIDTH+1], mul_acc[WIDTH+1:1]};
                q_d   = {mul_acc[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
            end else begin
                acc_d = sum;
                q_d   = {q_q[WIDTH-2:0], ~sum[WIDTH+1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            sgn_q  <= 1'b0;
            qneg_q <= 1'b0;
            bfix_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
`ifdef MD_SEQ_REMAINDER_EN
            rneg_q <= 1'b0;
            dvd_q  <= '0;
            rem_q  <= '0;
`endif
        end else begin
            acc_q  <= acc_d;
            q_q    <= q_d;
            m_q    <= m_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_d;
            sgn_q  <= sgn_d;
            qneg_q <= qneg_d;
            bfix_q <= bfix_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            res_q  <= res_d;
            exc_q  <= exc_d;
            rdy_q  <= rdy_d;
`ifdef MD_SEQ_REMAINDER_EN
            rneg_q <= rneg_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
`ifdef MD_SEQ_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

endmodule
